// File: rtl/alu_core_if.sv
// alu_core_if: operand/result bundle for alu_core.
//   a_in, b_in : operands, [0:WIDTH-1], index 0 is the MSB
//   op_in      : operation select, [0:2], index 0 is the MSB
//   y_out      : registered result, [0:WIDTH-1], index 0 is the MSB
//   z_out      : registered zero flag
// master drives operands and observes results; slave is the ALU side.
interface alu_core_if #(
  parameter int WIDTH = 32
);
  logic [0:WIDTH-1] a_in;
  logic [0:WIDTH-1] b_in;
  logic [0:2]       op_in;
  logic [0:WIDTH-1] y_out;
  logic             z_out;

  modport master (
    output a_in, b_in, op_in,
    input  y_out, z_out
  );

  modport slave (
    input  a_in, b_in, op_in,
    output y_out, z_out
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: single-cycle registered ALU.
//   clk_in : rising-edge clock
//   rst_in : synchronous active-high reset (y_out -> 0, z_out -> 1)
//   bus    : alu_core_if slave (a_in, b_in, op_in in; y_out, z_out out)
// op_in: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed),
//        110 SLL, 111 SRL (shift amount = 5 LSBs of b).
// The result is formed combinationally and registered every edge;
// latency is one cycle with no handshake.
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic      clk_in,
  input  logic      rst_in,
  alu_core_if.slave bus
);

  localparam int SHAMT_W = 5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  // The big-endian port vectors keep their numeric value when copied into
  // little-endian locals, so all arithmetic below is ordinary unsigned math.
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [2:0]       op_p0;
  logic [WIDTH-1:0] y_nxt_p0;

  logic [WIDTH-1:0] y_p1;
  logic             z_p1;

  function automatic logic [WIDTH-1:0] alu_eval(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op
  );
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [SHAMT_W-1:0]      shamt;
    logic [WIDTH-1:0]        r;
    sa    = a;
    sb    = b;
    shamt = b[SHAMT_W-1:0];
    r     = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLL:  r = a << shamt;
      OP_SRL:  r = a >> shamt;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stage p0: combinational evaluation of the current operands
  assign a_p0  = bus.a_in;
  assign b_p0  = bus.b_in;
  assign op_p0 = bus.op_in;

  always_comb begin
    y_nxt_p0 = alu_eval(a_p0, b_p0, op_p0);
  end

  // Stage p1: result and zero flag registered together; reset wins
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      y_p1 <= '0;
      z_p1 <= 1'b1;
    end else begin
      y_p1 <= y_nxt_p0;
      z_p1 <= (y_nxt_p0 == '0);
    end
  end

  assign bus.y_out = y_p1;
  assign bus.z_out = z_p1;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed-vector bench for alu_core (WIDTH=32) with a
// behavioural reference model compared every cycle plus literal checks.
module tb_alu_core;

  logic clk;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  alu_core_if #(.WIDTH(32)) bus ();

  alu_core #(.WIDTH(32)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model written from the operation table using 64-bit
  // arithmetic, powers of two and integer comparison.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    longint unsigned la, lb, m, p;
    int sa, sb;
    la = a; lb = b;
    m  = 64'h1_0000_0000;
    p  = 64'd1 << (lb % 32);
    sa = a; sb = b;
    case (op)
      3'd0: return 32'((la + lb) % m);
      3'd1: return 32'((la + m - lb) % m);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return 32'((la * p) % m);
      default: return 32'(la / p);
    endcase
  endfunction

  logic [31:0] exp_y;
  logic        exp_z;
  logic        model_vld = 1'b0;
  logic [31:0] mval;

  always @(posedge clk) begin
    mval = model(bus.a_in, bus.b_in, bus.op_in);
    if (rst) begin
      exp_y <= 32'd0;
      exp_z <= 1'b1;
    end else begin
      exp_y <= mval;
      exp_z <= (mval == 32'd0);
    end
    model_vld <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_vld) begin
      check("model_y", bus.y_out, exp_y);
      check("model_z", {31'd0, bus.z_out}, {31'd0, exp_z});
    end
  end

  // Apply one vector, take one edge, then check literal expectations.
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op);
    rst       = r;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.op_in = op;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_yz(input string name, input logic [31:0] y, input logic z);
    check({name, "_y"}, bus.y_out, y);
    check({name, "_z"}, {31'd0, bus.z_out}, {31'd0, z});
  endtask

  initial begin
    rst = 1'b1; bus.a_in = '0; bus.b_in = '0; bus.op_in = '0;
    #2;

    // Reset state with live operands present
    step(1'b1, 32'd1, 32'd1, 3'd0);       expect_yz("reset", 32'd0, 1'b1);
    step(1'b0, 32'd1, 32'd1, 3'd0);       expect_yz("add_1_1", 32'd2, 1'b0);
    step(1'b0, 32'd5, 32'd5, 3'd1);       expect_yz("sub_5_5", 32'd0, 1'b1);
    step(1'b0, 32'd0, 32'd1, 3'd1);       expect_yz("sub_borrow", 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd2); expect_yz("and", 32'h00F0_00F0, 1'b0);
    step(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd3); expect_yz("or",  32'hFFF0_FFF0, 1'b0);
    step(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd4); expect_yz("xor", 32'hFF00_FF00, 1'b0);
    step(1'b0, 32'hFFFF_FFFF, 32'd1, 3'd5);         expect_yz("slt_neg", 32'd1, 1'b0);
    step(1'b0, 32'd1, 32'hFFFF_FFFF, 3'd5);         expect_yz("slt_pos", 32'd0, 1'b1);
    step(1'b0, 32'h8000_0001, 32'h21, 3'd6);        expect_yz("sll_hi_ignored", 32'h0000_0002, 1'b0);
    step(1'b0, 32'h8000_0001, 32'd4, 3'd7);         expect_yz("srl_4", 32'h0800_0000, 1'b0);
    step(1'b0, 32'hFFFF_FFFF, 32'd1, 3'd0);         expect_yz("add_wrap", 32'd0, 1'b1);

    // Shift boundaries
    step(1'b0, 32'h1234_5678, 32'hFFFF_FFE0, 3'd6); expect_yz("sll_0", 32'h1234_5678, 1'b0);
    step(1'b0, 32'h1234_5678, 32'd0, 3'd7);         expect_yz("srl_0", 32'h1234_5678, 1'b0);
    step(1'b0, 32'h0000_0003, 32'd31, 3'd6);        expect_yz("sll_31", 32'h8000_0000, 1'b0);
    step(1'b0, 32'hC000_0000, 32'd31, 3'd7);        expect_yz("srl_31", 32'h0000_0001, 1'b0);
    step(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 3'd5); expect_yz("slt_min_max", 32'd1, 1'b0);
    step(1'b0, 32'd7, 32'd7, 3'd5);                 expect_yz("slt_equal", 32'd0, 1'b1);

    // Inputs moving between edges must not disturb the registered result
    bus.a_in = 32'hDEAD_BEEF; bus.b_in = 32'h1; bus.op_in = 3'd0;
    #2;
    expect_yz("hold_between_edges", 32'd0, 1'b1);

    // Reset / release / mid-stream reset sequence
    step(1'b1, 32'd1, 32'd1, 3'd0);       expect_yz("seq_rst", 32'd0, 1'b1);
    step(1'b0, 32'd1, 32'd1, 3'd0);       expect_yz("seq_release", 32'd2, 1'b0);
    step(1'b1, 32'd1, 32'd1, 3'd0);       expect_yz("seq_midrst", 32'd0, 1'b1);
    step(1'b0, 32'h0F0F_0000, 32'h0000_F0F0, 3'd3); expect_yz("after_rst_or", 32'h0F0F_F0F0, 1'b0);

    // A few more mixed vectors covered by the model only
    step(1'b0, 32'h7FFF_FFFF, 32'd1, 3'd0);
    step(1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 3'd1);
    step(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 3'd4);
    step(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 3'd2);
    step(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'd5);
    step(1'b0, 32'hFFFF_FFFF, 32'd16, 3'd7);
    step(1'b0, 32'hFFFF_FFFF, 32'd16, 3'd6);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
